// File: rtl/imem_program_loader.sv
// Instruction-memory program loader.
// Receives a length-prefixed byte stream, packs it big-endian into 32-bit
// words and writes them into instruction memory. The CPU is held until the
// program has loaded without error.
// Optional build macro: IMEM_LOADER_CHECKSUM_EN adds a trailing XOR checksum
// byte to the frame.
//
// state  | meaning
// -------+-----------------------------------------------------------
// IDLE   | waiting for start after reset
// LEN_HI | taking high byte of the word count
// LEN_LO | taking low byte of the word count, then range check
// DATA   | taking the 4 bytes of the current word
// WRITE  | one-cycle memory write of the assembled word
// CHK    | taking the trailing checksum byte (checksum build only)
// DONE   | load finished (done=1), CPU released unless error
module imem_program_loader #(
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
  parameter int          MAX_WORDS = 256
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        start,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  output logic        rx_ready,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic        cpu_hold,
  output logic        busy,
  output logic        done,
  output logic        error
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LEN_HI,
    S_LEN_LO,
    S_DATA,
    S_WRITE,
    S_CHK,
    S_DONE
  } state_t;

  localparam logic [16:0] MAX_W = 17'(MAX_WORDS);

`ifdef IMEM_LOADER_CHECKSUM_EN
  localparam state_t AFTER_LOAD = S_CHK;
`else
  localparam state_t AFTER_LOAD = S_DONE;
`endif

  state_t      state, state_nxt;
  logic [15:0] len_q;
  logic [15:0] word_idx;
  logic [1:0]  byte_cnt;
  logic [31:0] word_q;
  logic        err_q;
  logic [15:0] len_new;
  logic        len_too_big;
  logic        last_word;
  logic        take;
  logic        start_ok;

`ifdef IMEM_LOADER_CHECKSUM_EN
  logic [7:0]  csum_q;
`endif

  // The full count is only known while LEN_LO is on the bus.
  assign len_new     = {len_q[15:8], rx_data};
  assign len_too_big = {1'b0, len_new} > MAX_W;
  assign last_word   = ({1'b0, word_idx} + 17'd1) >= {1'b0, len_q};
  assign take        = rx_valid && rx_ready;
  assign start_ok    = start && ((state == S_IDLE) || (state == S_DONE));

  assign mem_addr  = BASE_ADDR + {14'b0, word_idx, 2'b00};
  assign mem_wdata = word_q;
  assign error     = err_q;

  // State register.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) state <= S_IDLE;
    else       state <= state_nxt;
  end

  // Next-state and state-decoded outputs; rx_ready is a pure state decode.
  always_comb begin
    state_nxt = state;
    rx_ready  = 1'b0;
    mem_we    = 1'b0;
    busy      = 1'b1;
    done      = 1'b0;
    cpu_hold  = 1'b1;
    case (state)
      S_IDLE: begin
        busy = 1'b0;
        if (start) state_nxt = S_LEN_HI;
      end
      S_LEN_HI: begin
        rx_ready = 1'b1;
        if (rx_valid) state_nxt = S_LEN_LO;
      end
      S_LEN_LO: begin
        rx_ready = 1'b1;
        if (rx_valid) begin
          if (len_too_big)          state_nxt = S_DONE;
          else if (len_new == 16'd0) state_nxt = AFTER_LOAD;
          else                       state_nxt = S_DATA;
        end
      end
      S_DATA: begin
        rx_ready = 1'b1;
        if (rx_valid && (byte_cnt == 2'd3)) state_nxt = S_WRITE;
      end
      S_WRITE: begin
        mem_we = 1'b1;
        if (last_word) state_nxt = AFTER_LOAD;
        else           state_nxt = S_DATA;
      end
      S_CHK: begin
        rx_ready = 1'b1;
        if (rx_valid) state_nxt = S_DONE;
      end
      S_DONE: begin
        busy     = 1'b0;
        done     = 1'b1;
        cpu_hold = err_q;
        if (start) state_nxt = S_LEN_HI;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // Datapath: length capture, word assembly, word index and error flag.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      len_q    <= 16'd0;
      word_idx <= 16'd0;
      byte_cnt <= 2'd0;
      word_q   <= 32'd0;
      err_q    <= 1'b0;
    end else begin
      if (start_ok) begin
        word_idx <= 16'd0;
        byte_cnt <= 2'd0;
        err_q    <= 1'b0;
      end
      case (state)
        S_LEN_HI: if (take) len_q[15:8] <= rx_data;
        S_LEN_LO: begin
          if (take) begin
            len_q[7:0] <= rx_data;
            byte_cnt   <= 2'd0;
            word_idx   <= 16'd0;
            if (len_too_big) err_q <= 1'b1;
          end
        end
        S_DATA: begin
          if (take) begin
            word_q   <= {word_q[23:0], rx_data};
            byte_cnt <= byte_cnt + 2'd1;
          end
        end
        S_WRITE: word_idx <= word_idx + 16'd1;
`ifdef IMEM_LOADER_CHECKSUM_EN
        S_CHK: if (take && (rx_data != csum_q)) err_q <= 1'b1;
`endif
        default: ;
      endcase
    end
  end

`ifdef IMEM_LOADER_CHECKSUM_EN
  // Running XOR over every accepted frame byte before the checksum byte.
  always_ff @(posedge clock or posedge reset) begin
    if (reset)                         csum_q <= 8'd0;
    else if (start_ok)                 csum_q <= 8'd0;
    else if (take && (state != S_CHK)) csum_q <= csum_q ^ rx_data;
  end
`endif

endmodule

// File: tb/tb_imem_program_loader.sv
// Self-checking bench for imem_program_loader: directed frames plus random
// frames, compared against a frame-level model of the expected writes.
module tb_imem_program_loader;

  localparam logic [31:0] BASE = 32'h0000_0000;
  localparam int          MAXW = 256;

  typedef logic [7:0] bq_t[$];
  typedef logic [31:0] wq_t[$];
  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
  } wr_t;

  logic        clock = 1'b0;
  logic        reset, start, rx_valid, rx_ready, mem_we, cpu_hold, busy, done, error;
  logic [7:0]  rx_data;
  logic [31:0] mem_addr, mem_wdata;

  wr_t exp_q[$];
  int  vectors = 0;
  int  miscompares = 0;

  imem_program_loader #(.BASE_ADDR(BASE), .MAX_WORDS(MAXW)) dut (
    .clock(clock), .reset(reset), .start(start), .rx_data(rx_data),
    .rx_valid(rx_valid), .rx_ready(rx_ready), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .cpu_hold(cpu_hold),
    .busy(busy), .done(done), .error(error)
  );

  always #5 clock = ~clock;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    vectors++;
    if (act !== req) begin
      miscompares++;
      $display("FAIL %s: got %h, expected %h", name, act, req);
    end
  endtask

  // Every cycle: output relationships and write-port contents versus the model.
  always @(negedge clock) begin
    if (!reset) begin
      check("hold_rule", {31'b0, cpu_hold}, {31'b0, !(done && !error)});
      check("ready_we_exclusive", {31'b0, rx_ready & mem_we}, 32'd0);
      check("busy_done_exclusive", {31'b0, busy & done}, 32'd0);
      if (mem_we) begin
        if (exp_q.size() == 0) begin
          vectors++;
          miscompares++;
          $display("FAIL unexpected_write: addr %h data %h, expected no write", mem_addr, mem_wdata);
        end else begin
          wr_t w;
          w = exp_q.pop_front();
          check("write_addr", mem_addr, w.addr);
          check("write_data", mem_wdata, w.data);
        end
      end
    end
  end

  // Frame model: builds the byte stream and queues the writes it must produce.
  task automatic make_frame(input int n, input wq_t words, input bit bad_ck,
                            output bq_t bytes, output bit exp_err);
    logic [15:0] n16;
    logic [7:0]  x;
    wr_t         w;
    n16 = n[15:0];
    bytes = {};
    bytes.push_back(n16[15:8]);
    bytes.push_back(n16[7:0]);
    if (n > MAXW) begin
      exp_err = 1'b1;
      return;
    end
    for (int i = 0; i < n; i++) begin
      for (int b = 3; b >= 0; b--) bytes.push_back(8'(words[i] >> (8 * b)));
      w.addr = BASE + 32'(4 * i);
      w.data = words[i];
      exp_q.push_back(w);
    end
`ifdef IMEM_LOADER_CHECKSUM_EN
    x = 8'h00;
    foreach (bytes[k]) x = x ^ bytes[k];
    bytes.push_back(bad_ck ? (x ^ 8'h5A) : x);
    exp_err = bad_ck;
`else
    x = 8'h00;
    exp_err = 1'b0;
`endif
  endtask

  // Offer each byte until the handshake completes. mode 0: valid held high,
  // 1: valid toggles every cycle, 2: random gaps. start pulses at byte start_at.
  task automatic send_bytes(input bq_t b, input int mode, input int start_at);
    bit tog = 1'b1;
    bit hs;
    for (int i = 0; i < b.size(); i++) begin
      int tries = 0;
      bit accepted = 1'b0;
      while (!accepted) begin
        rx_data = b[i];
        case (mode)
          0:       rx_valid = 1'b1;
          1:       begin rx_valid = tog; tog = !tog; end
          default: rx_valid = ($urandom_range(0, 3) != 0);
        endcase
        start = (i == start_at) && (tries == 0);
        @(negedge clock);
        hs = rx_valid && rx_ready;
        @(posedge clock);
        #1;
        start = 1'b0;
        if (hs) accepted = 1'b1;
        tries++;
        if (!accepted && tries > 100) begin
          vectors++;
          miscompares++;
          $display("FAIL byte_timeout: byte %0d not accepted, expected acceptance", i);
          rx_valid = 1'b0;
          return;
        end
      end
    end
    rx_valid = 1'b0;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(posedge clock);
    #1;
    start = 1'b0;
  endtask

  task automatic finish_frame(input string name, input bit exp_err);
    int k = 0;
    while (!done && k < 20) begin
      @(posedge clock);
      #1;
      k++;
    end
    check({name, "_done"}, {31'b0, done}, 32'd1);
    check({name, "_error"}, {31'b0, error}, {31'b0, exp_err});
    check({name, "_cpu_hold"}, {31'b0, cpu_hold}, {31'b0, exp_err});
    check({name, "_busy"}, {31'b0, busy}, 32'd0);
    check({name, "_writes_left"}, exp_q.size(), 32'd0);
    exp_q.delete();
  endtask

  task automatic check_reset_vals(input string name);
    check({name, "_rx_ready"}, {31'b0, rx_ready}, 32'd0);
    check({name, "_mem_we"}, {31'b0, mem_we}, 32'd0);
    check({name, "_mem_addr"}, mem_addr, BASE);
    check({name, "_mem_wdata"}, mem_wdata, 32'd0);
    check({name, "_cpu_hold"}, {31'b0, cpu_hold}, 32'd1);
    check({name, "_busy"}, {31'b0, busy}, 32'd0);
    check({name, "_done"}, {31'b0, done}, 32'd0);
    check({name, "_error"}, {31'b0, error}, 32'd0);
  endtask

  initial begin
    bq_t b;
    wq_t w;
    bit  ee;
    wr_t lw;

    reset = 1'b1; start = 1'b0; rx_valid = 1'b0; rx_data = 8'h00;
    #3;
    check_reset_vals("reset");
    @(posedge clock); #1;
    reset = 1'b0;

    // T1: two words, rx_valid held high, literal expectations.
    pulse_start();
    lw.addr = 32'h0; lw.data = 32'h2008_0005; exp_q.push_back(lw);
    lw.addr = 32'h4; lw.data = 32'hAC09_0000; exp_q.push_back(lw);
    b = '{8'h00, 8'h02, 8'h20, 8'h08, 8'h00, 8'h05, 8'hAC, 8'h09, 8'h00, 8'h00};
`ifdef IMEM_LOADER_CHECKSUM_EN
    b.push_back(8'h8A);
`endif
    send_bytes(b, 0, -1);
    finish_frame("t1", 1'b0);

    // T2: N=257 is rejected right after the header.
    pulse_start();
    b = '{8'h01, 8'h01};
    send_bytes(b, 0, -1);
    check("t2_done_next_cycle", {31'b0, done}, 32'd1);
    finish_frame("t2", 1'b1);

    // T3: N=1, toggled valid, stray start mid-frame, then no further bytes taken.
    pulse_start();
    w = '{32'hDEAD_BEEF};
    make_frame(1, w, 1'b0, b, ee);
    send_bytes(b, 1, 3);
    finish_frame("t3", ee);
    rx_valid = 1'b1; rx_data = 8'h77;
    for (int i = 0; i < 3; i++) begin
      @(negedge clock);
      check("t3_no_extra_byte", {31'b0, rx_ready}, 32'd0);
    end
    @(posedge clock); #1;
    rx_valid = 1'b0;

    // T6: N=0, done one cycle after the last frame byte.
    pulse_start();
    w = {};
    make_frame(0, w, 1'b0, b, ee);
    send_bytes(b, 0, -1);
    check("t6_done_next_cycle", {31'b0, done}, 32'd1);
    finish_frame("t6", ee);

`ifdef IMEM_LOADER_CHECKSUM_EN
    // T5: wrong then correct checksum.
    pulse_start();
    lw.addr = BASE; lw.data = 32'h1234_5678; exp_q.push_back(lw);
    b = '{8'h00, 8'h01, 8'h12, 8'h34, 8'h56, 8'h78, 8'h08};
    send_bytes(b, 0, -1);
    finish_frame("t5_bad", 1'b1);
    pulse_start();
    lw.addr = BASE; lw.data = 32'h1234_5678; exp_q.push_back(lw);
    b = '{8'h00, 8'h01, 8'h12, 8'h34, 8'h56, 8'h78, 8'h09};
    send_bytes(b, 0, -1);
    finish_frame("t5_good", 1'b0);
`endif

    // T4: asynchronous reset after 6 bytes of an N=2 frame.
    pulse_start();
    w = '{32'h0102_0304, 32'hA5A5_5A5A};
    make_frame(2, w, 1'b0, b, ee);
    b = b[0:5];
    send_bytes(b, 0, -1);
    @(posedge clock);
    #3;
    reset = 1'b1;
    #1;
    check_reset_vals("t4_async");
    exp_q.delete();
    @(posedge clock); #1;
    reset = 1'b0;
    pulse_start();
    w = '{32'h0BAD_F00D, 32'h7654_3210};
    make_frame(2, w, 1'b0, b, ee);
    send_bytes(b, 2, -1);
    finish_frame("t4_reload", ee);

    // Boundary: exactly MAX_WORDS words is accepted.
    pulse_start();
    w = {};
    for (int i = 0; i < MAXW; i++) w.push_back($urandom());
    make_frame(MAXW, w, 1'b0, b, ee);
    send_bytes(b, 0, -1);
    finish_frame("max_words", ee);

    // Random frames.
    for (int f = 0; f < 24; f++) begin
      int n;
      bit bad;
      n = ($urandom_range(0, 7) == 0) ? int'($urandom_range(257, 65535)) : int'($urandom_range(0, 6));
      bad = ($urandom_range(0, 2) == 0);
      w = {};
      for (int i = 0; i < n && i <= MAXW; i++) w.push_back($urandom());
      pulse_start();
      make_frame(n, w, bad, b, ee);
      send_bytes(b, int'($urandom_range(0, 2)), int'($urandom_range(0, 12)));
      finish_frame("random", ee);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
